// File: rtl/struct_byte_write_seq_if.sv
// Request/observation bundle for struct_byte_write_seq: the producer drives the
// req_* group, the sequencer drives ready, the packed struct and status flags.
interface struct_byte_write_seq_if #(
  parameter int NBYTES = 8,
  parameter int FILLW  = 16
);
  localparam int IW = $clog2(NBYTES);
  localparam int LW = $clog2(NBYTES) + 1;
  localparam int SW = 8 * NBYTES + FILLW;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  // The producer holds all req_* fields stable while req_valid is high and not yet
  // accepted; req_ready depends only on the sequencer state, never on req_valid.
  logic              req_valid;
  logic              req_ready;
  logic [IW-1:0]     req_idx;
  logic [LW-1:0]     req_len;
  logic [8*NBYTES-1:0] req_data;
  logic              req_fill_we;
  logic [FILLW-1:0]  req_fill_data;
  logic [SW-1:0]     state_out;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        dbg_state;

  modport master (
    output req_valid, req_idx, req_len, req_data, req_fill_we, req_fill_data,
    input  req_ready, state_out, busy, done, err, dbg_state
  );

  modport slave (
    input  req_valid, req_idx, req_len, req_data, req_fill_we, req_fill_data,
    output req_ready, state_out, busy, done, err, dbg_state
  );
endinterface

// File: rtl/struct_byte_write_seq.sv
// Serialises range-checked multi-byte slice writes into a packed {a[], b} struct,
// one byte element per cycle, with an optional filler update on the last byte.
module struct_byte_write_seq #(
  parameter int NBYTES = 8,
  parameter int FILLW  = 16,
  parameter int IW     = $clog2(NBYTES),
  parameter int LW     = $clog2(NBYTES) + 1
) (
  input logic                     clk,
  input logic                     rst,
  struct_byte_write_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } fsm_e;

  typedef struct packed {
    logic [NBYTES-1:0][7:0] a;
    logic [FILLW-1:0]       b;
  } st_t;

  localparam logic [LW:0] NB_L = (LW+1)'(NBYTES);

  fsm_e                   fsm_q, fsm_d;
  st_t                    st_q, st_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [LW-1:0]          len_q, len_d;
  logic [NBYTES-1:0][7:0] data_q, data_d;
  logic                   fw_q, fw_d;
  logic [FILLW-1:0]       fd_q, fd_d;
  logic [IW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [LW:0]            end_sum;
  logic                   bad_req;
  logic [IW-1:0]          widx;
  logic                   last;

  // End index is formed one bit wider than the length so idx+len never wraps.
  assign end_sum = {1'b0, {1'b0, bus.req_idx}} + {1'b0, bus.req_len};
  assign bad_req = (bus.req_len == '0) || (end_sum > NB_L);
  assign widx    = idx_q + cnt_q;
  assign last    = ({1'b0, cnt_q} + LW'(1)) == len_q;

  always_comb begin
    fsm_d  = fsm_q;
    st_d   = st_q;
    idx_d  = idx_q;
    len_d  = len_q;
    data_d = data_q;
    fw_d   = fw_q;
    fd_d   = fd_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    ready  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            idx_d  = bus.req_idx;
            len_d  = bus.req_len;
            data_d = bus.req_data;
            fw_d   = bus.req_fill_we;
            fd_d   = bus.req_fill_data;
            cnt_d  = '0;
            fsm_d  = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        busy         = 1'b1;
        st_d.a[widx] = data_q[cnt_q];
        if (last) begin
          if (fw_q) st_d.b = fd_q;
          cnt_d = '0;
          fsm_d = S_DONE;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      S_DONE: begin
        done  = 1'b1;
        fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= S_IDLE;
      st_q   <= '0;
      idx_q  <= '0;
      len_q  <= '0;
      data_q <= '0;
      fw_q   <= 1'b0;
      fd_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      idx_q  <= idx_d;
      len_q  <= len_d;
      data_q <= data_d;
      fw_q   <= fw_d;
      fd_q   <= fd_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err_q;
  assign bus.state_out = st_q;
  assign bus.dbg_state = fsm_q;

endmodule

// File: tb/tb_struct_byte_write_seq.sv
// Directed bench for struct_byte_write_seq with NBYTES=8, FILLW=16.
module tb_struct_byte_write_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [79:0] exp_q[$];

  struct_byte_write_seq_if #(.NBYTES(8), .FILLW(16)) bus ();

  struct_byte_write_seq #(.NBYTES(8), .FILLW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: issue one request and wait (bounded) for its done pulse
  task automatic run_req(input logic [2:0] idx, input logic [3:0] len,
                         input logic [63:0] data, input logic fw, input logic [15:0] fd,
                         output int lat, output int bcnt, output int ecnt);
    @(negedge clk);
    bus.req_idx       = idx;
    bus.req_len       = len;
    bus.req_data      = data;
    bus.req_fill_we   = fw;
    bus.req_fill_data = fd;
    bus.req_valid     = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat  = 0;
    bcnt = 0;
    ecnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.err) ecnt++;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic reject(input string tag, input logic [2:0] idx, input logic [3:0] len,
                        input logic [79:0] exp_st);
    @(negedge clk);
    bus.req_idx       = idx;
    bus.req_len       = len;
    bus.req_data      = 64'hDEAD_BEEF_CAFE_F00D;
    bus.req_fill_we   = 1'b1;
    bus.req_fill_data = 16'h5A5A;
    bus.req_valid     = 1'b1;
    chk({tag, "_ready_pre"}, bus.req_ready, 1'b1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_err"}, bus.err, 1'b1);
    chk({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_ready"}, bus.req_ready, 1'b1);
    chk({tag, "_state"}, bus.state_out, exp_st);
    @(negedge clk);
    chk({tag, "_err_off"}, bus.err, 1'b0);
    chk({tag, "_done_off"}, bus.done, 1'b0);
    chk({tag, "_state2"}, bus.state_out, exp_st);
  endtask

  initial begin
    int lat, bcnt, ecnt, acc, dcnt;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_idx       = '0;
    bus.req_len       = '0;
    bus.req_data      = '0;
    bus.req_fill_we   = 1'b0;
    bus.req_fill_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", bus.state_out, 80'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", bus.req_ready, 1'b1);
    chk("idle_fsm", bus.dbg_state, 2'd0);

    // idx=1 len=2
    exp_q.push_back(80'h0000_0000_0012_3400_0000);
    run_req(3'd1, 4'd2, 64'h1234, 1'b0, 16'h0, lat, bcnt, ecnt);
    chk("r1_lat", lat, 3);
    chk("r1_busy", bcnt, 2);
    chk("r1_err", ecnt, 0);
    chk("r1_state", bus.state_out, exp_q.pop_front());
    @(negedge clk);
    chk("r1_done_once", bus.done, 1'b0);
    chk("r1_ready_back", bus.req_ready, 1'b1);

    exp_q.push_back(80'h0000_4200_0012_3400_0000);
    run_req(3'd5, 4'd1, 64'h42, 1'b0, 16'h0, lat, bcnt, ecnt);
    chk("r2_lat", lat, 2);
    chk("r2_state", bus.state_out, exp_q.pop_front());

    exp_q.push_back(80'hFC00_4200_0012_3400_FFFC);
    run_req(3'd7, 4'd1, 64'hFC, 1'b1, 16'hFFFC, lat, bcnt, ecnt);
    chk("r3_lat", lat, 2);
    chk("r3_state", bus.state_out, exp_q.pop_front());

    // range and zero-length rejections
    reject("rej_over", 3'd7, 4'd2, 80'hFC00_4200_0012_3400_FFFC);
    reject("rej_zero", 3'd0, 4'd0, 80'hFC00_4200_0012_3400_FFFC);

    // whole array, filler untouched
    exp_q.push_back({64'h0102_0304_0506_0708, 16'hFFFC});
    run_req(3'd0, 4'd8, 64'h0102_0304_0506_0708, 1'b0, 16'h1111, lat, bcnt, ecnt);
    chk("full_lat", lat, 9);
    chk("full_busy", bcnt, 8);
    chk("full_state", bus.state_out, exp_q.pop_front());

    // async reset during the third byte of a len=6 request
    @(negedge clk);
    bus.req_idx       = 3'd0;
    bus.req_len       = 4'd6;
    bus.req_data      = 64'h0000_6655_4433_2211;
    bus.req_fill_we   = 1'b1;
    bus.req_fill_data = 16'h7777;
    bus.req_valid     = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_busy", bus.busy, 1'b1);
    chk("mid_partial", bus.state_out, {64'h0102_0304_0506_2211, 16'hFFFC});
    rst = 1'b1;
    #1;
    chk("arst_state", bus.state_out, 80'h0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_fsm", bus.dbg_state, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_ready", bus.req_ready, 1'b1);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    chk("arst_no_done", dcnt, 0);
    chk("arst_state_hold", bus.state_out, 80'h0);

    // back-to-back with req_valid held high
    @(negedge clk);
    bus.req_idx       = 3'd0;
    bus.req_len       = 4'd2;
    bus.req_data      = 64'hAABB;
    bus.req_fill_we   = 1'b0;
    bus.req_fill_data = 16'h0;
    bus.req_valid     = 1'b1;
    chk("b2b_ready_a", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req_idx  = 3'd4;
    bus.req_len  = 4'd1;
    bus.req_data = 64'hCC;
    acc  = 0;
    dcnt = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
      if (bus.req_ready) begin
        acc = e;
        break;
      end
    end
    chk("b2b_accept_slot", acc, 4);
    chk("b2b_a_done", dcnt, 1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    chk("b2b_b_lat", lat, 2);
    chk("b2b_state", bus.state_out, 80'h0000_00CC_0000_AABB_0000);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    chk("b2b_no_dup", dcnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
